// File: rtl/muldiv_seq.sv
// Multi-cycle MIPS-style multiply/divide sequencer driving a shared external add/sub unit.
// Operands are made positive, iterated WIDTH times (shift-add / restoring divide), then sign-fixed.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ctrl,
  output logic             add_sign,
  input  logic [WIDTH-1:0] add_dout,
  input  logic             add_z,
  input  logic             add_v
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi, r_lo, r_d;
  logic [WIDTH-1:0] r_hi_q, r_lo_q;
  logic [CW-1:0]    r_cnt;
  logic             r_sgn, r_div, r_rs_msb, r_rt_msb, r_lz;
  logic             r_busy, r_done;

  logic [WIDTH-1:0] w_s;
  logic             w_q, w_neg;

  // Divide step: partial remainder shifted left by one; a bit shifted out of hi
  // means s >= 2^WIDTH > d, so the subtraction always succeeds.
  assign w_s   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_q   = r_hi[WIDTH-1] | ~add_v;
  assign w_neg = r_sgn & (r_rs_msb ^ r_rt_msb);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_ctrl = 1'b0;
    unique case (r_state)
      S_NEG_A:  begin add_b = r_lo; add_ctrl = 1'b1; end
      S_NEG_B:  begin add_b = r_d;  add_ctrl = 1'b1; end
      S_ITER: begin
        if (r_div) begin
          add_a    = w_s;
          add_b    = r_d;
          add_ctrl = 1'b1;
        end else begin
          add_a = r_hi;
          add_b = r_lo[0] ? r_d : '0;
        end
      end
      S_FIX_LO: begin add_b = r_lo; add_ctrl = 1'b1; end
      S_FIX_HI: begin add_b = r_hi; add_ctrl = 1'b1; end
      default: ;
    endcase
  end

  assign add_sign = 1'b0;
  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi_q;
  assign lo       = r_lo_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_d      <= '0;
      r_hi_q   <= '0;
      r_lo_q   <= '0;
      r_cnt    <= '0;
      r_sgn    <= 1'b0;
      r_div    <= 1'b0;
      r_rs_msb <= 1'b0;
      r_rt_msb <= 1'b0;
      r_lz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Status and result outputs trail the internal state by one cycle.
      r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
      r_done <= (r_state == S_DONE);
      r_hi_q <= r_hi;
      r_lo_q <= r_lo;

      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_hi     <= '0;
            r_lo     <= rs;
            r_d      <= rt;
            r_sgn    <= ~op[0];
            r_div    <= op[1];
            r_rs_msb <= rs[WIDTH-1];
            r_rt_msb <= rt[WIDTH-1];
            r_state  <= S_NEG_A;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_NEG_A: begin
          if (r_sgn && r_lo[WIDTH-1]) r_lo <= add_dout;
          r_state <= S_NEG_B;
        end
        S_NEG_B: begin
          if (r_sgn && r_d[WIDTH-1]) r_d <= add_dout;
          r_cnt   <= CW'(WIDTH);
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (r_div) begin
            r_hi <= w_q ? add_dout : w_s;
            r_lo <= {r_lo[WIDTH-2:0], w_q};
          end else begin
            r_hi <= {add_v, add_dout[WIDTH-1:1]};
            r_lo <= {add_dout[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX_LO;
        end
        S_FIX_LO: begin
          if (w_neg) r_lo <= add_dout;
          r_lz    <= add_z;
          r_state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          // A zero low word carries into hi, so the 64-bit negate needs 0-hi instead of ~hi.
          if (r_div) begin
            if (r_sgn && r_rs_msb) r_hi <= add_dout;
          end else if (w_neg) begin
            r_hi <= r_lz ? add_dout : ~r_hi;
          end
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: models the external add/sub unit and checks
// latency, busy window, results, ignored starts, reset abort and back-to-back issue.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo, add_a, add_b, add_dout;
  logic        add_ctrl, add_sign, add_z, add_v;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int sign_bad = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .add_a(add_a), .add_b(add_b), .add_ctrl(add_ctrl), .add_sign(add_sign),
    .add_dout(add_dout), .add_z(add_z), .add_v(add_v)
  );

  always #5 clk = ~clk;

  // Unsigned add/sub unit: V is carry-out on add, borrow on sub.
  always_comb begin
    logic [32:0] t;
    t = '0;
    if (add_ctrl) t = {1'b0, add_a} - {1'b0, add_b};
    else          t = {1'b0, add_a} + {1'b0, add_b};
    add_dout = t[31:0];
    add_v    = t[32];
    add_z    = (t[31:0] == 32'd0);
  end

  always @(negedge clk) if (add_sign !== 1'b0) sign_bad++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op (unless skip_start: already accepted at the previous edge), waits for
  // done, and checks latency, busy window and result. At edge inj it raises start for
  // one cycle with the n_* operands.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit skip_start, input int inj,
                        input logic [1:0] n_op, input logic [31:0] n_a, input logic [31:0] n_b);
    int lat, busy_bad;
    lat = 0;
    busy_bad = 0;
    if (!skip_start) begin
      op = o; rs = a; rt = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rs = 32'h5A5A_1234; rt = 32'h0F0F_0003;
    end
    for (int n = 1; n <= 60; n++) begin
      if (n == inj) begin op = n_op; rs = n_a; rt = n_b; start = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy !== (n <= 36)) busy_bad++;
      if (done === 1'b1) begin lat = n; break; end
    end
    check({tag, "_latency"}, 32'(lat), 32'd37);
    check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 0, 0, 0);
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 0, 0, 0);
    run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 0, 0, 0, 0);
    run_op("mult_lozero", OP_MULT, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0, 0);
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0, 0, 0);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, 0, 0, 0);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0, 0, 0, 0);
    run_op("div_m5by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, 0, 0, 0, 0, 0);

    // Start pulse at edge 10 must be ignored.
    run_op("multu_ignore", OP_MULTU, 32'h0001_0001, 32'h0001_0001, 32'h1, 32'h0002_0001,
           0, 10, OP_DIVU, 32'h0000_DEAD, 32'd3);

    // Reset at edge 15 aborts with no done pulse.
    op = OP_MULT; rs = 32'd6; rt = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done === 1'b1) done_seen++; end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op("mult_after_abort", OP_MULT, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 0, 0, 0, 0);

    // Back-to-back: multu 3x4 accepted in the DONE cycle of divu 100/7.
    run_op("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 37, OP_MULTU, 32'd3, 32'd4);
    run_op("b2b_second", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1, 0, 0, 0, 0);

    check("add_sign_zero", 32'(sign_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
